cycle_latency_probe: RTL

//  Measures start->stop latency in clock cycles from timestamps of the free-running wrapping cycle counter.

---
 rtl/latency_probe_pkg.sv | 27 ++
 rtl/latency_stats_accum.sv | 50 +++++
 rtl/cycle_latency_probe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/latency_probe_pkg.sv
// Shared types and helpers for the cycle latency probe.
// Optional statistics block is enabled by defining LATENCY_PROBE_STATS_EN.
package latency_probe_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SUM_W  = 48;
  localparam int unsigned NCNT_W = 16;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Distance from b forward to a on a counter that wraps with the given period.
  function automatic logic [CNT_W-1:0] mod_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b,
                                                input logic [CNT_W:0]   period);
    logic [CNT_W:0] w_d;
    if (a >= b) w_d = {1'b0, a} - {1'b0, b};
    else        w_d = {1'b0, a} + period - {1'b0, b};
    return CNT_W'(w_d);
  endfunction

endpackage

// File: rtl/latency_stats_accum.sv
// Running min/max/sum/count of accepted latency samples, all saturating.
// Only instanced when LATENCY_PROBE_STATS_EN is defined.
module latency_stats_accum
  import latency_probe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_upd,
  input  logic [CNT_W-1:0]    i_latency,
  output logic [CNT_W-1:0]    o_min,
  output logic [CNT_W-1:0]    o_max,
  output logic [SUM_W-1:0]    o_sum,
  output logic [NCNT_W-1:0]   o_n
);

  logic [CNT_W-1:0]  r_min;
  logic [CNT_W-1:0]  r_max;
  logic [SUM_W-1:0]  r_sum;
  logic [NCNT_W-1:0] r_n;
  logic [SUM_W:0]    w_sum_ext;

  assign w_sum_ext = {1'b0, r_sum} + (SUM_W+1)'(i_latency);

  // Clear wins over a same-cycle sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= TIMEOUT_VAL;
      r_max <= '0;
      r_sum <= '0;
      r_n   <= '0;
    end else if (i_clear) begin
      r_min <= TIMEOUT_VAL;
      r_max <= '0;
      r_sum <= '0;
      r_n   <= '0;
    end else if (i_upd) begin
      if (i_latency < r_min) r_min <= i_latency;
      if (i_latency > r_max) r_max <= i_latency;
      r_sum <= w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
      if (r_n != {NCNT_W{1'b1}}) r_n <= r_n + NCNT_W'(1);
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;
  assign o_sum = r_sum;
  assign o_n   = r_n;

endmodule

// File: rtl/cycle_latency_probe.sv
// Start->stop latency probe using timestamps from a wrapping cycle counter.
// Define LATENCY_PROBE_STATS_EN to build the min/max/sum/n statistics.
module cycle_latency_probe
  import latency_probe_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 32'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] count,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_latency,
  output logic        out_timeout,
  output logic        busy,
  output logic [15:0] drop_count,
  output logic [31:0] stat_min,
  output logic [31:0] stat_max,
  output logic [47:0] stat_sum,
  output logic [15:0] stat_n
);

  localparam logic [CNT_W:0] PERIOD = (CNT_W+1)'(MAX_COUNT) + (CNT_W+1)'(1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_start_ts;
  logic [CNT_W-1:0]   w_start_ts_nxt;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_out_latency;
  logic [CNT_W-1:0]   w_lat_nxt;
  logic               r_out_timeout;
  logic               w_to_nxt;
  logic               r_busy;
  logic [NCNT_W-1:0]  r_drop_count;
  logic               w_drop_inc;
  logic               w_handshake;

  assign w_handshake = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_start_ts_nxt = r_start_ts;
    w_lat_nxt      = r_out_latency;
    w_to_nxt       = r_out_timeout;
    w_drop_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_start_ts_nxt = count;
          w_state_nxt    = ARMED;
        end else if (start && stop) begin
          w_lat_nxt   = '0;
          w_to_nxt    = 1'b0;
          w_state_nxt = HOLD;
        end
      end
      ARMED: begin
        w_drop_inc = start;
        // Stop takes precedence over a full-period timeout on the same cycle.
        if (stop) begin
          w_lat_nxt   = mod_diff(count, r_start_ts, PERIOD);
          w_to_nxt    = 1'b0;
          w_state_nxt = HOLD;
        end else if (count == r_start_ts) begin
          w_lat_nxt   = TIMEOUT_VAL;
          w_to_nxt    = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_drop_inc = start;
        if (w_handshake) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_ts    <= '0;
      r_out_valid   <= 1'b0;
      r_out_latency <= '0;
      r_out_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_start_ts    <= w_start_ts_nxt;
      r_out_valid   <= (w_state_nxt == HOLD);
      r_out_latency <= w_lat_nxt;
      r_out_timeout <= w_to_nxt;
      r_busy        <= (w_state_nxt == ARMED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_drop_count <= '0;
    else if (clear)                                     r_drop_count <= '0;
    else if (w_drop_inc && (r_drop_count != 16'hFFFF))  r_drop_count <= r_drop_count + NCNT_W'(1);
  end

  assign out_valid   = r_out_valid;
  assign out_latency = r_out_latency;
  assign out_timeout = r_out_timeout;
  assign busy        = r_busy;
  assign drop_count  = r_drop_count;

`ifdef LATENCY_PROBE_STATS_EN
  logic w_stat_upd;
  assign w_stat_upd = w_handshake & ~r_out_timeout;

  latency_stats_accum u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_upd     (w_stat_upd),
    .i_latency (r_out_latency),
    .o_min     (stat_min),
    .o_max     (stat_max),
    .o_sum     (stat_sum),
    .o_n       (stat_n)
  );
`else
  assign stat_min = '0;
  assign stat_max = '0;
  assign stat_sum = '0;
  assign stat_n   = '0;
`endif

endmodule
